sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Parameters
REQ-001 SHALL have parameter NPORTS, default 3, meaning the number of requester ports (2..8).
REQ-002 SHALL have parameter RD_DEPTH, default 4, meaning the maximum number of outstanding reads tracked (power of 2, 2..16).

Interface
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port p_read  input  NPORTS  per-port read request, held until accepted.
REQ-006 SHALL have port p_write  input  NPORTS  per-port write request, held until accepted.
REQ-007 SHALL have port p_addr  input  NPORTS x 26  per-port address {chip, bank[1:0], row[12:0], col[9:0]}.
REQ-008 SHALL have port p_wdata  input  NPORTS x 16  per-port write word.
REQ-009 SHALL have port p_ready  output  NPORTS  one-hot accept strobe; a request is taken on any edge where p_ready[i] is high.
REQ-010 SHALL have port p_rdata  output  16  read word, shared by all ports.
REQ-011 SHALL have port p_rdata_val  output  NPORTS  one-hot read-data-valid for the owning port.
REQ-012 SHALL have port m_read  output  1  read command to the SDRAM controller.
REQ-013 SHALL have port m_write  output  1  write command to the SDRAM controller.
REQ-014 SHALL have port m_addr  output  26  address to the controller.
REQ-015 SHALL have port m_wdata  output  16  write word to the controller.
REQ-016 SHALL have port m_cmd_ready  input  1  high when the controller accepts a command on the next edge.
REQ-017 SHALL have port m_rdata  input  16  controller read data.
REQ-018 SHALL have port m_rdata_val  input  1  controller read-data-valid, one word per read, returned in issue order.
REQ-019 SHALL have port err_orphan  output  1  sticky flag: read data arrived with no outstanding read.

Function
REQ-020 SHALL consider port i requesting when p_read[i] | p_write[i]; if both are high, the request SHALL be treated as a read.
REQ-021 SHALL select a winner combinationally by round-robin: the first requesting port at or after rr_ptr, wrapping modulo NPORTS.
REQ-022 SHALL drive m_read, m_write, m_addr and m_wdata combinationally from the winner; with no requester, m_read=m_write=0 and m_addr=m_wdata=0.
REQ-023 SHALL suppress a read winner (m_read=0, no p_ready) while the tag FIFO is full; a write winner is unaffected by FIFO state.
REQ-024 SHALL, when the winner is a suppressed read, not pass the grant to another port that cycle; this blocking is intentional.
REQ-025 SHALL assert p_ready[winner] = m_cmd_ready & (m_read | m_write) & ~reset_active; all other p_ready bits SHALL be 0.
REQ-026 SHALL, on an accepted command, load rr_ptr with (winner+1) mod NPORTS; rr_ptr SHALL otherwise hold.
REQ-027 SHALL, on an accepted read, push the winner index into the tag FIFO (RD_DEPTH entries; occupancy count 0..RD_DEPTH).
REQ-028 SHALL, on m_rdata_val with the FIFO non-empty, pop the head tag and set p_rdata_val[tag]=1 in the same cycle (combinational, zero latency).
REQ-029 SHALL drive p_rdata = m_rdata at all times.
REQ-030 SHALL apply a simultaneous push and pop in one cycle with the count unchanged, including when count=RD_DEPTH-1 or count=1.
REQ-031 SHALL compute "full" from the registered count only; a pop in the same cycle SHALL NOT unblock a read.
REQ-032 SHALL, on m_rdata_val with the FIFO empty, keep p_rdata_val all zero, discard the data, and set err_orphan=1 until reset.
REQ-033 SHALL wrap the FIFO read and write pointers modulo RD_DEPTH.

Reset
REQ-034 SHALL, while reset=0 (asynchronous), set rr_ptr=0, FIFO count and pointers=0, and err_orphan=0, and SHALL force p_ready=0 and p_rdata_val=0.
REQ-035 SHALL discard all outstanding read tags on a reset mid-operation; read data returned after reset deasserts SHALL be handled per REQ-032.

Verification
REQ-036 SHALL verify round-robin: all 3 ports request reads continuously with m_cmd_ready=1 -> grants in order 0,1,2,0,1,2 with rr_ptr=0 after reset.
REQ-037 SHALL verify read routing: port 2 reads 0x0000123 then port 0 reads 0x1000040; m_rdata_val returns 0xAAAA, then 0x5555 -> p_rdata_val[2] with 0xAAAA first, then p_rdata_val[0] with 0x5555.
REQ-038 SHALL verify backpressure: 4 reads accepted with no return -> a 5th read request sees p_ready=0 and m_read=0, while a concurrent write from another port is still not granted (REQ-024); one m_rdata_val -> read is accepted the following cycle.
REQ-039 SHALL verify stall: m_cmd_ready=0 for 10 cycles with port 1 writing 0xBEEF -> p_ready stays 0 and m_write=1, m_wdata=0xBEEF are held; m_cmd_ready=1 -> a single p_ready[1] pulse is issued.
REQ-040 SHALL verify orphan and reset: m_rdata_val with an empty FIFO -> err_orphan=1 and no p_rdata_val; then reset asserted mid-cycle with 2 reads outstanding -> immediate p_ready=0, and count=0, err_orphan=0 after release.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between NPORTS requesters, the arbiter and one SDRAM controller.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface sdram_arbiter_if #(
  parameter int unsigned NPORTS = 3
);
  logic [NPORTS-1:0]       p_read;
  logic [NPORTS-1:0]       p_write;
  logic [NPORTS-1:0][25:0] p_addr;
  logic [NPORTS-1:0][15:0] p_wdata;
  logic [NPORTS-1:0]       p_ready;
  logic [15:0]             p_rdata;
  logic [NPORTS-1:0]       p_rdata_val;
  logic                    m_read;
  logic                    m_write;
  logic [25:0]             m_addr;
  logic [15:0]             m_wdata;
  logic                    m_cmd_ready;
  logic [15:0]             m_rdata;
  logic                    m_rdata_val;

  modport master (
    input  p_read, p_write, p_addr, p_wdata, m_cmd_ready, m_rdata, m_rdata_val,
    output p_ready, p_rdata, p_rdata_val, m_read, m_write, m_addr, m_wdata
  );

  modport slave (
    output p_read, p_write, p_addr, p_wdata, m_cmd_ready, m_rdata, m_rdata_val,
    input  p_ready, p_rdata, p_rdata_val, m_read, m_write, m_addr, m_wdata
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller among NPORTS requesters;
// a tag FIFO routes in-order read data back to the port that issued each read.
module sdram_arbiter #(
  parameter int unsigned NPORTS   = 3,
  parameter int unsigned RD_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  sdram_arbiter_if.master  bus,
  output logic             err_orphan
);
  localparam int unsigned PW = $clog2(NPORTS);
  localparam int unsigned TW = $clog2(RD_DEPTH);
  localparam int unsigned CW = TW + 1;

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     winner;
  logic              found;
  logic [NPORTS-1:0] req;
  logic              win_read;
  logic              win_write;
  logic              full;
  logic              accept;
  logic              push;
  logic              pop;
  logic [TW-1:0]     wr_ptr;
  logic [TW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [PW-1:0]     tags [RD_DEPTH];
  int unsigned       idx;

  assign req = bus.p_read | bus.p_write;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!found && req[PW'(idx)]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  // A full FIFO stalls a read winner without handing the slot to anyone else.
  assign win_read  = found & bus.p_read[winner];
  assign win_write = found & ~bus.p_read[winner] & bus.p_write[winner];
  assign full      = (count == CW'(RD_DEPTH));

  assign bus.m_read  = win_read & ~full;
  assign bus.m_write = win_write;
  assign bus.m_addr  = found ? bus.p_addr[winner]  : '0;
  assign bus.m_wdata = found ? bus.p_wdata[winner] : '0;

  assign accept      = bus.m_cmd_ready & (bus.m_read | bus.m_write) & reset;
  assign push        = accept & bus.m_read;
  assign pop         = bus.m_rdata_val & (count != '0) & reset;

  assign bus.p_ready     = accept ? (NPORTS'(1) << winner) : '0;
  assign bus.p_rdata_val = pop ? (NPORTS'(1) << tags[rd_ptr]) : '0;
  assign bus.p_rdata     = bus.m_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (accept) rr_ptr <= (winner == PW'(NPORTS - 1)) ? '0 : winner + PW'(1);
      if (push) wr_ptr <= wr_ptr + TW'(1);
      if (pop)  rd_ptr <= rd_ptr + TW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.m_rdata_val && (count == '0)) err_orphan <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= winner;
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter (NPORTS=3, RD_DEPTH=4): arbitration order,
// read routing, FIFO backpressure, controller stall, orphan data and reset.
module tb_sdram_arbiter;
  logic clk;
  logic reset;
  logic err_orphan;
  int   vectors;
  int   miscompares;

  sdram_arbiter_if #(.NPORTS(3)) bus ();

  sdram_arbiter #(.NPORTS(3), .RD_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.master),
    .err_orphan (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.p_read = '0; bus.p_write = '0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.m_cmd_ready = 1'b1; bus.m_rdata = '0; bus.m_rdata_val = 1'b0;
    #23;
    vectors++; if (bus.p_ready !== 3'b000) begin miscompares++; $display("FAIL rst_p_ready got %b exp 000", bus.p_ready); end
    vectors++; if (bus.p_rdata_val !== 3'b000) begin miscompares++; $display("FAIL rst_p_rdata_val got %b exp 000", bus.p_rdata_val); end
    vectors++; if (err_orphan !== 1'b0) begin miscompares++; $display("FAIL rst_err_orphan got %b exp 0", err_orphan); end
    vectors++; if (bus.m_read !== 1'b0 || bus.m_addr !== 26'h0) begin miscompares++; $display("FAIL rst_idle_bus got m_read=%b m_addr=%h exp 0/0", bus.m_read, bus.m_addr); end
    vectors++; if (dut.count !== 3'd0) begin miscompares++; $display("FAIL rst_count got %0d exp 0", dut.count); end
    #1 reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_gnt;
    logic [2:0] exp_val;
    for (int i = 0; i < 3; i++) bus.p_addr[i] = 26'h100 + 26'(i);
    for (int k = 0; k < 6; k++) begin
      bus.p_read = 3'b111;
      bus.m_rdata_val = (k > 0);
      #2;
      exp_gnt = 3'b001 << (k % 3);
      exp_val = (k > 0) ? (3'b001 << ((k - 1) % 3)) : 3'b000;
      vectors++; if (bus.p_ready !== exp_gnt) begin miscompares++; $display("FAIL rr_grant k=%0d got %b exp %b", k, bus.p_ready, exp_gnt); end
      vectors++; if (bus.m_read !== 1'b1 || bus.m_addr !== 26'h100 + 26'(k % 3)) begin miscompares++; $display("FAIL rr_cmd k=%0d got m_read=%b m_addr=%h exp 1/%h", k, bus.m_read, bus.m_addr, 26'h100 + 26'(k % 3)); end
      vectors++; if (bus.p_rdata_val !== exp_val) begin miscompares++; $display("FAIL rr_rdata_val k=%0d got %b exp %b", k, bus.p_rdata_val, exp_val); end
      next_cycle();
    end
    bus.p_read = 3'b000; bus.m_rdata_val = 1'b1;
    #2;
    vectors++; if (bus.p_rdata_val !== 3'b100) begin miscompares++; $display("FAIL rr_drain got %b exp 100", bus.p_rdata_val); end
    next_cycle();
    bus.m_rdata_val = 1'b0;
  endtask

  task automatic test_read_routing();
    bus.p_read = 3'b100; bus.p_addr[2] = 26'h0000123;
    #2;
    vectors++; if (bus.p_ready !== 3'b100 || bus.m_addr !== 26'h0000123) begin miscompares++; $display("FAIL route_rd2 got p_ready=%b m_addr=%h exp 100/0000123", bus.p_ready, bus.m_addr); end
    next_cycle();
    bus.p_read = 3'b001; bus.p_addr[0] = 26'h1000040;
    #2;
    vectors++; if (bus.p_ready !== 3'b001 || bus.m_addr !== 26'h1000040) begin miscompares++; $display("FAIL route_rd0 got p_ready=%b m_addr=%h exp 001/1000040", bus.p_ready, bus.m_addr); end
    next_cycle();
    bus.p_read = 3'b000; bus.m_rdata_val = 1'b1; bus.m_rdata = 16'hAAAA;
    #2;
    vectors++; if (bus.p_rdata_val !== 3'b100 || bus.p_rdata !== 16'hAAAA) begin miscompares++; $display("FAIL route_ret1 got val=%b data=%h exp 100/aaaa", bus.p_rdata_val, bus.p_rdata); end
    next_cycle();
    bus.m_rdata = 16'h5555;
    #2;
    vectors++; if (bus.p_rdata_val !== 3'b001 || bus.p_rdata !== 16'h5555) begin miscompares++; $display("FAIL route_ret2 got val=%b data=%h exp 001/5555", bus.p_rdata_val, bus.p_rdata); end
    next_cycle();
    bus.m_rdata_val = 1'b0;
    #2;
    vectors++; if (dut.count !== 3'd0 || err_orphan !== 1'b0) begin miscompares++; $display("FAIL route_idle got count=%0d orphan=%b exp 0/0", dut.count, err_orphan); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [2:0] drain [3];
    drain[0] = 3'b001; drain[1] = 3'b010; drain[2] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      bus.p_read = 3'b001;
      #2;
      vectors++; if (bus.p_ready !== 3'b001) begin miscompares++; $display("FAIL bp_fill k=%0d got %b exp 001", k, bus.p_ready); end
      next_cycle();
    end
    bus.p_read = 3'b010; bus.p_write = 3'b100;
    for (int k = 0; k < 2; k++) begin
      #2;
      vectors++; if (bus.p_ready !== 3'b000 || bus.m_read !== 1'b0 || bus.m_write !== 1'b0) begin miscompares++; $display("FAIL bp_block k=%0d got p_ready=%b m_read=%b m_write=%b exp 000/0/0", k, bus.p_ready, bus.m_read, bus.m_write); end
      next_cycle();
    end
    bus.m_rdata_val = 1'b1;
    #2;
    vectors++; if (bus.p_ready !== 3'b000 || bus.p_rdata_val !== 3'b001) begin miscompares++; $display("FAIL bp_pop_same got p_ready=%b val=%b exp 000/001", bus.p_ready, bus.p_rdata_val); end
    next_cycle();
    bus.m_rdata_val = 1'b0;
    #2;
    vectors++; if (bus.p_ready !== 3'b010 || bus.m_read !== 1'b1) begin miscompares++; $display("FAIL bp_unblock got p_ready=%b m_read=%b exp 010/1", bus.p_ready, bus.m_read); end
    next_cycle();
    bus.p_read = 3'b000;
    #2;
    vectors++; if (bus.p_ready !== 3'b100 || bus.m_write !== 1'b1) begin miscompares++; $display("FAIL bp_write_full got p_ready=%b m_write=%b exp 100/1", bus.p_ready, bus.m_write); end
    next_cycle();
    bus.p_write = 3'b000; bus.m_rdata_val = 1'b1;
    #2;
    vectors++; if (bus.p_rdata_val !== 3'b001) begin miscompares++; $display("FAIL bp_pop got %b exp 001", bus.p_rdata_val); end
    next_cycle();
    bus.p_read = 3'b001;
    #2;
    vectors++; if (bus.p_ready !== 3'b001 || bus.p_rdata_val !== 3'b001) begin miscompares++; $display("FAIL bp_push_pop got p_ready=%b val=%b exp 001/001", bus.p_ready, bus.p_rdata_val); end
    next_cycle();
    bus.p_read = 3'b000;
    #2;
    vectors++; if (dut.count !== 3'd3) begin miscompares++; $display("FAIL bp_count_hold got %0d exp 3", dut.count); end
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (bus.p_rdata_val !== drain[k]) begin miscompares++; $display("FAIL bp_drain k=%0d got %b exp %b", k, bus.p_rdata_val, drain[k]); end
      next_cycle();
      #1;
    end
    bus.m_rdata_val = 1'b0;
    #1;
    vectors++; if (dut.count !== 3'd0 || err_orphan !== 1'b0) begin miscompares++; $display("FAIL bp_empty got count=%0d orphan=%b exp 0/0", dut.count, err_orphan); end
    next_cycle();
  endtask

  task automatic test_stall();
    bus.m_cmd_ready = 1'b0; bus.p_write = 3'b010;
    bus.p_wdata[1] = 16'hBEEF; bus.p_addr[1] = 26'h2ABCDEF;
    for (int k = 0; k < 10; k++) begin
      #2;
      vectors++; if (bus.p_ready !== 3'b000 || bus.m_write !== 1'b1 || bus.m_wdata !== 16'hBEEF || bus.m_addr !== 26'h2ABCDEF) begin miscompares++; $display("FAIL stall_hold k=%0d got p_ready=%b m_write=%b m_wdata=%h m_addr=%h", k, bus.p_ready, bus.m_write, bus.m_wdata, bus.m_addr); end
      next_cycle();
    end
    bus.m_cmd_ready = 1'b1;
    #2;
    vectors++; if (bus.p_ready !== 3'b010) begin miscompares++; $display("FAIL stall_release got %b exp 010", bus.p_ready); end
    next_cycle();
    bus.p_write = 3'b000;
    #2;
    vectors++; if (bus.p_ready !== 3'b000 || bus.m_write !== 1'b0) begin miscompares++; $display("FAIL stall_single got p_ready=%b m_write=%b exp 000/0", bus.p_ready, bus.m_write); end
    next_cycle();
  endtask

  task automatic test_orphan_reset();
    bus.m_rdata_val = 1'b1; bus.m_rdata = 16'h1234;
    #2;
    vectors++; if (bus.p_rdata_val !== 3'b000 || bus.p_rdata !== 16'h1234) begin miscompares++; $display("FAIL orphan_val got val=%b data=%h exp 000/1234", bus.p_rdata_val, bus.p_rdata); end
    next_cycle();
    bus.m_rdata_val = 1'b0;
    #2;
    vectors++; if (err_orphan !== 1'b1) begin miscompares++; $display("FAIL orphan_flag got %b exp 1", err_orphan); end
    bus.p_read = 3'b001;
    #1;
    vectors++; if (bus.p_ready !== 3'b001) begin miscompares++; $display("FAIL orphan_rd0 got %b exp 001", bus.p_ready); end
    next_cycle();
    bus.p_read = 3'b010;
    #2;
    vectors++; if (bus.p_ready !== 3'b010) begin miscompares++; $display("FAIL orphan_rd1 got %b exp 010", bus.p_ready); end
    next_cycle();
    bus.p_read = 3'b100;
    #2;
    vectors++; if (bus.p_ready !== 3'b100 || dut.count !== 3'd2) begin miscompares++; $display("FAIL pre_reset got p_ready=%b count=%0d exp 100/2", bus.p_ready, dut.count); end
    #1 reset = 1'b0;
    bus.m_rdata_val = 1'b1;
    #1;
    vectors++; if (bus.p_ready !== 3'b000 || bus.p_rdata_val !== 3'b000) begin miscompares++; $display("FAIL reset_force got p_ready=%b val=%b exp 000/000", bus.p_ready, bus.p_rdata_val); end
    vectors++; if (dut.count !== 3'd0 || err_orphan !== 1'b0) begin miscompares++; $display("FAIL reset_clear got count=%0d orphan=%b exp 0/0", dut.count, err_orphan); end
    bus.p_read = 3'b000; bus.m_rdata_val = 1'b0;
    @(posedge clk);
    #4 reset = 1'b1;
    #1;
    vectors++; if (dut.count !== 3'd0 || err_orphan !== 1'b0) begin miscompares++; $display("FAIL post_reset got count=%0d orphan=%b exp 0/0", dut.count, err_orphan); end
    next_cycle();
    bus.m_rdata_val = 1'b1;
    #2;
    vectors++; if (bus.p_rdata_val !== 3'b000) begin miscompares++; $display("FAIL stale_ret got %b exp 000", bus.p_rdata_val); end
    next_cycle();
    bus.m_rdata_val = 1'b0;
    #2;
    vectors++; if (err_orphan !== 1'b1) begin miscompares++; $display("FAIL stale_orphan got %b exp 1", err_orphan); end
    next_cycle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_round_robin();
    test_read_routing();
    test_backpressure();
    test_stall();
    test_orphan_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
